spi_master_ctrl: RTL
====================

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 Parameter WL, default 16, SPI frame length in bits, MSB first; legal range 2..32.
REQ-002 Parameter DIV, default 2, system clocks per SCLK half-period; legal range 1..255.
REQ-003 iCLK  input  1  system clock; all state changes on its rising edge.
REQ-004 iRST  input  1  reset, asynchronous, active-high.
REQ-005 iREQ0  input  1  requester 0 transfer request, level, held until oGNT0.
REQ-006 iDAT0  input  WL  requester 0 transmit word, held stable while iREQ0 is high.
REQ-007 oGNT0  output  1  one-cycle pulse; iDAT0 was captured and requester 0 owns the transfer.
REQ-008 iREQ1, iDAT1, oGNT1 SHALL behave as REQ-005..REQ-007 for requester 1.
REQ-009 oOWNER  output  1  index of the requester owning the current or last transfer.
REQ-010 oBUSY  output  1  high from the grant cycle through the oDONE cycle inclusive.
REQ-011 oDONE  output  1  one-cycle pulse at end of transfer; oRDAT is valid from this cycle.
REQ-012 oRDAT  output  WL  received word, held until the next oDONE.
REQ-013 oSCLK  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-014 oMOSI  output  1  SPI serial data out.
REQ-015 iMISO  input  1  SPI serial data in.
REQ-016 oCS_N  output  1  chip select, active-low.

Function
REQ-017 The FSM SHALL use states IDLE, SETUP, SHIFT, HOLD and DONE: IDLE->SETUP on any request sampled high; SETUP->SHIFT after DIV cycles; SHIFT->HOLD after 2*WL*DIV cycles; HOLD->DONE after DIV cycles; DONE->IDLE after 1 cycle.
REQ-018 On the IDLE->SETUP edge the block SHALL latch the winner's iDAT into the TX shift register, pulse that requester's oGNT for one cycle, set oOWNER, and drive oCS_N low.
REQ-019 oMOSI SHALL equal the TX register MSB from the first SETUP cycle onward; the TX register SHALL shift left on each SCLK falling edge in SHIFT.
REQ-020 oSCLK SHALL toggle every DIV cycles in SHIFT, starting low and rising first, giving exactly WL rising edges; oSCLK SHALL be low in all other states.
REQ-021 iMISO SHALL be sampled into the RX register LSB, shifting left, on each SCLK rising edge.
REQ-022 In DONE, oCS_N SHALL return high, oRDAT SHALL load from the RX register, and oDONE SHALL pulse.
REQ-023 oDONE SHALL assert exactly (2*WL+2)*DIV cycles after the oGNT pulse; the next oGNT SHALL come no earlier than 2 cycles after oDONE.
REQ-024 The half-period divider SHALL count 0..DIV-1 and wrap; the edge counter SHALL count 0..2*WL-1 and wrap to 0 on leaving SHIFT.
REQ-025 A request withdrawn before it is granted SHALL be ignored; requests arriving while oBUSY is high SHALL wait, with no queue depth beyond the level hold.
REQ-026 Simultaneous requests SHALL be resolved per REQ-030/REQ-031; at most one oGNT SHALL be high in any cycle.

Reset
REQ-027 While iRST is high: state IDLE, oCS_N=1, oSCLK=0, oMOSI=0, oGNT0=oGNT1=0, oBUSY=0, oDONE=0, oRDAT=0, oOWNER=0, counters=0, RR pointer favouring requester 0.
REQ-028 Reset asserted mid-transfer SHALL deassert oCS_N asynchronously and SHALL abort the transfer with no oDONE pulse.
REQ-029 After iRST falls, the first grant SHALL occur no earlier than the second iCLK rising edge.

Configuration
REQ-030 With SPI_ARB_RR_EN defined, arbitration SHALL be round-robin: on a tie, the requester not granted last wins, and the pointer updates on each grant.
REQ-031 Without SPI_ARB_RR_EN, arbitration SHALL be fixed priority: requester 0 always wins a tie, and no pointer register exists.

Verification
REQ-032 WL=16, DIV=2, iREQ0 with iDAT0=16'hA5C3, iMISO looped to oMOSI -> oGNT0 pulse, 16 SCLK rising edges, oDONE exactly 68 cycles after oGNT0, oRDAT=16'hA5C3, oOWNER=0.
REQ-033 iREQ0 and iREQ1 held high together for 3 transfers -> RR build grants 0,1,0; fixed build grants 0,0,0.
REQ-034 iRST pulsed during SHIFT at edge 7 -> oCS_N=1 and oSCLK=0 immediately, no oDONE; a fresh transfer then completes correctly.
REQ-035 DIV=1, iMISO tied 1, iDAT1=16'h0000 -> oMOSI low throughout, oRDAT=16'hFFFF, SCLK period 2 cycles.
REQ-036 iREQ1 raised in the oDONE cycle of a requester-0 transfer -> oGNT1 asserts exactly 2 cycles after oDONE.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: two-requester SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
//
// Ports
//   iCLK, iRST          system clock, asynchronous active-high reset
//   iREQ0/iDAT0/oGNT0   requester 0: level request, transmit word, grant pulse
//   iREQ1/iDAT1/oGNT1   requester 1: same as requester 0
//   oOWNER              requester owning the current or last transfer
//   oBUSY               high from the grant cycle through the oDONE cycle
//   oDONE, oRDAT        end-of-transfer pulse and received word (held to next oDONE)
//   oSCLK, oMOSI, iMISO, oCS_N   SPI bus
//
// Parameters: WL frame length (2..32), DIV system clocks per SCLK half-period (1..255).
// Build option: define SPI_ARB_RR_EN for round-robin arbitration; otherwise
// requester 0 has fixed priority.
module spi_master_ctrl #(
  parameter int WL  = 16,
  parameter int DIV = 2
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iREQ0,
  input  logic [WL-1:0] iDAT0,
  output logic          oGNT0,
  input  logic          iREQ1,
  input  logic [WL-1:0] iDAT1,
  output logic          oGNT1,
  output logic          oOWNER,
  output logic          oBUSY,
  output logic          oDONE,
  output logic [WL-1:0] oRDAT,
  output logic          oSCLK,
  output logic          oMOSI,
  input  logic          iMISO,
  output logic          oCS_N
);

  localparam int            EW        = $clog2(2 * WL);
  localparam logic [7:0]    DIV_LAST  = 8'(DIV - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(2 * WL - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t        state_q, state_d;
  logic [WL-1:0] tx_q, tx_d;
  logic [WL-1:0] rx_q, rx_d;
  logic [WL-1:0] rdat_q, rdat_d;
  logic [7:0]    div_q, div_d;
  logic [EW-1:0] edge_q, edge_d;
  logic          sclk_q, sclk_d;
  logic          cs_n_q, cs_n_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          owner_q, owner_d;
  logic          armed_q, armed_d;
  logic          win1;

`ifdef SPI_ARB_RR_EN
  // ptr_q = 1 means requester 1 wins the next tie.
  logic ptr_q, ptr_d;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) ptr_q <= 1'b0;
    else      ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdat_d  = rdat_q;
    div_d   = div_q;
    edge_d  = edge_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    owner_d = owner_q;
    // Blocks a grant on the first edge after reset release.
    armed_d = 1'b1;
`ifdef SPI_ARB_RR_EN
    ptr_d   = ptr_q;
    win1    = iREQ1 & (~iREQ0 | ptr_q);
`else
    win1    = iREQ1 & ~iREQ0;
`endif

    case (state_q)
      IDLE: begin
        if (armed_q && (iREQ0 || iREQ1)) begin
          state_d = SETUP;
          tx_d    = win1 ? iDAT1 : iDAT0;
          gnt0_d  = ~win1;
          gnt1_d  = win1;
          owner_d = win1;
          cs_n_d  = 1'b0;
          div_d   = '0;
`ifdef SPI_ARB_RR_EN
          ptr_d   = ~win1;
`endif
        end
      end
      SETUP: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = SHIFT;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          // Rising SCLK samples MISO; falling SCLK presents the next MOSI bit.
          if (!sclk_q) rx_d = {rx_q[WL-2:0], iMISO};
          else         tx_d = {tx_q[WL-2:0], 1'b0};
          if (edge_q == EDGE_LAST) begin
            edge_d  = '0;
            state_d = HOLD;
          end else begin
            edge_d = edge_q + 1'b1;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      HOLD: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = DONE;
          cs_n_d  = 1'b1;
          rdat_d  = rx_q;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      rdat_q  <= '0;
      div_q   <= '0;
      edge_q  <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      owner_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdat_q  <= rdat_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      owner_q <= owner_d;
      armed_q <= armed_d;
    end
  end

  assign oGNT0  = gnt0_q;
  assign oGNT1  = gnt1_q;
  assign oOWNER = owner_q;
  assign oBUSY  = (state_q != IDLE);
  assign oDONE  = (state_q == DONE);
  assign oRDAT  = rdat_q;
  assign oSCLK  = sclk_q;
  assign oMOSI  = tx_q[WL-1];
  assign oCS_N  = cs_n_q;

endmodule
